mcycle_ctrl: RTL

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/mcycle_ctrl.sv
// Multi-cycle (MUL/DIV) sequencing control: launches the op, stalls F/D/E while it runs,
// steers the saved context into M for one cycle when done, and flags a sticky timeout.
module mcycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        MCycleOpE,
  input  logic        CondExE,
  input  logic        FlushE,
  input  logic [3:0]  WA3E,
  input  logic        MCycleBusy,
  input  logic        MCycleDone,
  output logic        M_Start,
  output logic        M_Done,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushM,
  output logic        Busy,
  output logic [3:0]  PendWA3,
  output logic        MErr,
  output logic [15:0] PerfCnt
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_RUN = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   run_cnt;
  logic            stall;
  logic            start_req;
  logic            timeout;
  logic            unused_busy;

  // The unit's busy line is observed only for debug; it never steers control.
  assign unused_busy = MCycleBusy;

  // Qualified by nRESET so the Mealy start pulse is also silent during reset.
  assign start_req = nRESET & MCycleOpE & CondExE & ~FlushE;

  assign StallF = stall;
  assign StallD = stall;
  assign StallE = stall;

  always_comb begin
    next_state = state;
    M_Start    = 1'b0;
    M_Done     = 1'b0;
    stall      = 1'b0;
    FlushM     = 1'b0;
    Busy       = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          M_Start    = 1'b1;
          FlushM     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        stall  = 1'b1;
        FlushM = 1'b1;
        Busy   = 1'b1;
        // Done in the final allowed cycle still completes normally.
        if (MCycleDone) begin
          next_state = DONE;
        end else if (run_cnt == LAST_RUN) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      DONE: begin
        M_Done     = 1'b1;
        stall      = 1'b1;
        Busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      run_cnt <= '0;
      PendWA3 <= '0;
      MErr    <= 1'b0;
      PerfCnt <= '0;
    end else begin
      state <= next_state;
      if (M_Start) begin
        run_cnt <= '0;
        PendWA3 <= WA3E;
      end else if (state == RUN) begin
        run_cnt <= run_cnt + CW'(1);
      end
      if (timeout) begin
        MErr <= 1'b1;
      end
      if (Busy && (PerfCnt != '1)) begin
        PerfCnt <= PerfCnt + 16'd1;
      end
    end
  end

endmodule
